// File: rtl/pipe_fd_skid.sv
// Fetch/decode pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// READY_F is registered. FLUSH and CLR kill held instructions. STALL_CNT is a saturating counter of decode stalls.
`timescale 1ns/1ps
module pipe_fd_skid #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] NOP   = '0,
    parameter int               CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             FLUSH,
    input  logic             VALID_F,
    output logic             READY_F,
    input  logic [WIDTH-1:0] INSTR_F,
    input  logic [WIDTH-1:0] PCPLUS4_F,
    output logic             VALID_D,
    input  logic             READY_D,
    output logic [WIDTH-1:0] INSTR_D,
    output logic [WIDTH-1:0] PCPLUS4_D,
    output logic [CNT_W-1:0] STALL_CNT
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           r_state;
    logic             r_valid_d;
    logic             r_ready_f;
    logic [WIDTH-1:0] r_main_instr, r_main_pc;
    logic [WIDTH-1:0] r_skid_instr, r_skid_pc;
    logic [CNT_W-1:0] r_cnt;

    logic w_acc, w_rel;
    assign w_acc = VALID_F & r_ready_f;
    assign w_rel = r_valid_d & READY_D;

    // The main register is reloaded with the bubble on every entry to EMPTY, so the outputs come straight from flops.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state      <= EMPTY;
            r_valid_d    <= 1'b0;
            r_ready_f    <= 1'b1;
            r_main_instr <= NOP;
            r_main_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_cnt        <= '0;
        end else begin
            if (r_valid_d && !READY_D && r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (FLUSH) begin
                r_state      <= EMPTY;
                r_valid_d    <= 1'b0;
                r_ready_f    <= 1'b1;
                r_main_instr <= NOP;
                r_main_pc    <= '0;
            end else begin
                case (r_state)
                    EMPTY: if (w_acc) begin
                        r_state      <= ONE;
                        r_valid_d    <= 1'b1;
                        r_main_instr <= INSTR_F;
                        r_main_pc    <= PCPLUS4_F;
                    end
                    ONE: begin
                        if (w_acc && w_rel) begin
                            r_main_instr <= INSTR_F;
                            r_main_pc    <= PCPLUS4_F;
                        end else if (w_acc) begin
                            r_state      <= FULL;
                            r_ready_f    <= 1'b0;
                            r_skid_instr <= INSTR_F;
                            r_skid_pc    <= PCPLUS4_F;
                        end else if (w_rel) begin
                            r_state      <= EMPTY;
                            r_valid_d    <= 1'b0;
                            r_main_instr <= NOP;
                            r_main_pc    <= '0;
                        end
                    end
                    FULL: if (w_rel) begin
                        r_state      <= ONE;
                        r_ready_f    <= 1'b1;
                        r_main_instr <= r_skid_instr;
                        r_main_pc    <= r_skid_pc;
                    end
                    default: begin
                        r_state   <= EMPTY;
                        r_valid_d <= 1'b0;
                        r_ready_f <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign READY_F   = r_ready_f;
    assign VALID_D   = r_valid_d;
    assign INSTR_D   = r_main_instr;
    assign PCPLUS4_D = r_main_pc;
    assign STALL_CNT = r_cnt;
endmodule

// File: tb/tb_pipe_fd_skid.sv
// Bench for pipe_fd_skid. Directed scenarios plus random traffic are checked against a queue-based reference.
// A second instance with CNT_W=3 shares the stimulus so that counter saturation can be observed.
`timescale 1ns/1ps
module tb_pipe_fd_skid;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1, FLUSH = 1'b0, VALID_F = 1'b0, READY_D = 1'b0;
    logic [31:0] INSTR_F = '0, PCPLUS4_F = '0;
    logic        READY_F, VALID_D;
    logic [31:0] INSTR_D, PCPLUS4_D;
    logic [15:0] STALL_CNT;
    logic        s_ready_f, s_valid_d;
    logic [31:0] s_instr_d, s_pc_d;
    logic [2:0]  s_cnt;

    pipe_fd_skid #(.WIDTH(32), .NOP(NOP), .CNT_W(16)) u_dut (
        .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH), .VALID_F(VALID_F), .READY_F(READY_F),
        .INSTR_F(INSTR_F), .PCPLUS4_F(PCPLUS4_F), .VALID_D(VALID_D), .READY_D(READY_D),
        .INSTR_D(INSTR_D), .PCPLUS4_D(PCPLUS4_D), .STALL_CNT(STALL_CNT));

    pipe_fd_skid #(.WIDTH(32), .NOP(NOP), .CNT_W(3)) u_sat (
        .CLK(CLK), .CLR(CLR), .FLUSH(FLUSH), .VALID_F(VALID_F), .READY_F(s_ready_f),
        .INSTR_F(INSTR_F), .PCPLUS4_F(PCPLUS4_F), .VALID_D(s_valid_d), .READY_D(READY_D),
        .INSTR_D(s_instr_d), .PCPLUS4_D(s_pc_d), .STALL_CNT(s_cnt));

    always #5 CLK = ~CLK;

    int n_chk = 0, n_fail = 0;
    logic [63:0] mq[$];
    int m16 = 0, m3 = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ei, ep;
        ei = (mq.size() > 0) ? mq[0][63:32] : NOP;
        ep = (mq.size() > 0) ? mq[0][31:0]  : 32'h0;
        chk("valid_d", {63'h0, VALID_D}, {63'h0, mq.size() > 0});
        chk("ready_f", {63'h0, READY_F}, {63'h0, mq.size() < 2});
        chk("instr_d", {32'h0, INSTR_D}, {32'h0, ei});
        chk("pc_d", {32'h0, PCPLUS4_D}, {32'h0, ep});
        chk("stall_cnt", {48'h0, STALL_CNT}, 64'(m16));
        chk("sat_valid", {63'h0, s_valid_d}, {63'h0, mq.size() > 0});
        chk("sat_instr", {32'h0, s_instr_d}, {32'h0, ei});
        chk("sat_cnt", {61'h0, s_cnt}, 64'(m3));
    endtask

    // One clock: drive inputs, advance the reference from pre-edge state, then compare just after the edge.
    task automatic step(input bit clr, input bit fl, input bit vf,
                        input logic [31:0] ins, input logic [31:0] pc, input bit rd);
        bit acc, rel;
        CLR = clr; FLUSH = fl; VALID_F = vf; INSTR_F = ins; PCPLUS4_F = pc; READY_D = rd;
        acc = vf && (mq.size() < 2);
        rel = (mq.size() > 0) && rd;
        if (clr) begin
            mq.delete(); m16 = 0; m3 = 0;
        end else begin
            if (mq.size() > 0 && !rd) begin
                if (m16 < 65535) m16++;
                if (m3 < 7) m3++;
            end
            if (fl) mq.delete();
            else begin
                if (rel) void'(mq.pop_front());
                if (acc) mq.push_back({ins, pc});
            end
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    initial begin
        // Reset, then a three-instruction stream with decode always ready
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_instr", {32'h0, INSTR_D}, {32'h0, NOP});
        step(0, 0, 1, 1, 4, 1);
        chk("first_valid", {63'h0, VALID_D}, 64'h1);
        step(0, 0, 1, 2, 8, 1);
        step(0, 0, 1, 3, 12, 1);
        chk("stream_last", {32'h0, INSTR_D}, 64'h3);
        step(0, 0, 0, 0, 0, 1);

        // Back-pressure into the skid buffer; 3 is held until it is accepted
        step(0, 0, 1, 1, 4, 1);
        step(0, 0, 1, 2, 8, 0);
        chk("skid_ready", {63'h0, READY_F}, 64'h0);
        step(0, 0, 1, 3, 12, 0);
        chk("skid_hold", {32'h0, INSTR_D}, 64'h1);
        step(0, 0, 1, 3, 12, 1);
        step(0, 0, 1, 3, 12, 1);
        chk("skid_third", {32'h0, INSTR_D}, 64'h3);
        step(0, 0, 0, 0, 0, 1);

        // Flush while FULL; the instruction presented during the flush is dropped
        step(0, 0, 1, 5, 20, 0);
        step(0, 0, 1, 6, 24, 0);
        step(0, 1, 1, 7, 28, 0);
        chk("flush_pc", {32'h0, PCPLUS4_D}, 64'h0);
        step(0, 0, 1, 8, 32, 1);
        chk("after_flush", {32'h0, INSTR_D}, 64'h8);
        step(0, 0, 0, 0, 0, 1);

        // Bubbles
        step(0, 0, 1, 9, 36, 1);
        step(0, 0, 0, 0, 0, 1);
        chk("bubble", {32'h0, INSTR_D}, {32'h0, NOP});
        step(0, 0, 1, 10, 40, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset during a stall in FULL
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 11, 44, 0);
        step(0, 0, 1, 12, 48, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
        chk("stall4", {48'h0, STALL_CNT}, 64'h4);
        step(1, 0, 1, 13, 52, 0);
        chk("clr_cnt", {48'h0, STALL_CNT}, 64'h0);
        chk("clr_ready", {63'h0, READY_F}, 64'h1);

        // Saturation of the 3-bit counter
        step(0, 0, 1, 14, 56, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0);
        chk("sat7", {61'h0, s_cnt}, 64'h7);
        chk("wide10", {48'h0, STALL_CNT}, 64'd10);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                 $urandom, $urandom, $urandom_range(0, 9) < 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_fd_skid.md
Name: pipe_fd_skid

Overview:
Parametrised fetch/decode pipeline register; next generation of the plain F/D register.
- Adds a valid/ready handshake, a 2-entry skid buffer so fetch can back-pressure with a registered READY_F, a synchronous flush that kills in-flight instructions, and a saturating stall counter for performance monitoring.
- Sits between the fetch stage (instruction memory + PC+4 adder) and the decode stage.

Parameters:
- WIDTH, 32, width of instruction and PC+4 buses
- NOP, 32'h0000_0000, instruction word driven on INSTR_D when no valid instruction is held
- CNT_W, 16, width of STALL_CNT

Ports:
- CLK  input  1  clock, all state updates on rising edge
- CLR  input  1  synchronous active-high reset
- FLUSH  input  1  synchronous kill of all held instructions (branch/jump redirect)
- VALID_F  input  1  fetch presents a valid instruction
- READY_F  output  1  block can accept an instruction this cycle (registered)
- INSTR_F  input  WIDTH  fetched instruction
- PCPLUS4_F  input  WIDTH  PC+4 of fetched instruction
- VALID_D  output  1  INSTR_D/PCPLUS4_D hold a valid instruction
- READY_D  input  1  decode consumes the instruction this cycle (0 = stall)
- INSTR_D  output  WIDTH  instruction to decode
- PCPLUS4_D  output  WIDTH  PC+4 to decode
- STALL_CNT  output  CNT_W  cycles with VALID_D=1 and READY_D=0, saturating

Behaviour:
- Handshake terms:
  - acc = VALID_F & READY_F
  - rel = VALID_D & READY_D
- Storage: main register (drives the D outputs) and skid register; occupancy state EMPTY / ONE / FULL.
- READY_F = 1 in EMPTY and ONE, 0 in FULL. It is a pure function of registered state, with no combinational path from READY_D.
- Transitions, when CLR=0 and FLUSH=0:
  - EMPTY: acc -> ONE, main<=input; otherwise stay.
  - ONE, acc & rel: stay ONE, main<=input.
  - ONE, acc & !rel: -> FULL, skid<=input, main held.
  - ONE, !acc & rel: -> EMPTY.
  - ONE, !acc & !rel: hold.
  - FULL: acc impossible (READY_F=0). rel -> ONE, main<=skid; !rel -> hold both.
- Latency:
  - 1 cycle from acc to VALID_D when EMPTY, or when ONE with rel.
  - Order is strictly preserved; no instruction is dropped or duplicated except by FLUSH/CLR.
- While VALID_D=1 and READY_D=0, INSTR_D and PCPLUS4_D are held stable.
- When VALID_D=0: INSTR_D = NOP and PCPLUS4_D = 0 (bubble).
- FLUSH=1:
  - Next state EMPTY, VALID_D=0, READY_F=1.
  - Any instruction accepted in the same cycle (acc=1) is discarded.
  - Overrides all transitions; STALL_CNT unaffected.
- CLR=1:
  - Highest priority; identical effect to FLUSH, plus STALL_CNT<=0.
  - Reset values: VALID_D=0, INSTR_D=NOP, PCPLUS4_D=0, READY_F=1, STALL_CNT=0.
  - Valid mid-operation, including in FULL.
- STALL_CNT:
  - Increments by 1 each cycle VALID_D=1 & READY_D=0, evaluated before the edge.
  - Saturates at 2^CNT_W-1, no wrap.
- Skid contents are don't-care when not valid. Outputs never expose skid data directly.

Test Plan:
- Reset then stream: CLR=1 for 2 cycles, then VALID_F=1, READY_D=1, INSTR_F=1,2,3 with PCPLUS4_F=4,8,12 on successive cycles -> VALID_D rises one cycle after the first acc; INSTR_D/PCPLUS4_D = 1/4, 2/8, 3/12 on consecutive cycles; STALL_CNT=0.
- Back-pressure into skid:
  - Stream INSTR 1,2,3; drop READY_D to 0 after INSTR_D=1 appears.
  - Required: INSTR_D holds 1; 2 enters skid; READY_F=0 next cycle; 3 is not accepted.
  - Raise READY_D: D sequence 1,2,3 with no loss or duplication; STALL_CNT equals the number of stalled cycles.
- Flush in FULL: reach FULL (main=5, skid=6), assert FLUSH with VALID_F=1, INSTR_F=7 -> next cycle VALID_D=0, INSTR_D=NOP, PCPLUS4_D=0, READY_F=1; 7 discarded; the following acc of 8 appears alone.
- Bubbles: VALID_F toggles 1,0,1 (INSTR 9,-,10) with READY_D=1 -> VALID_D pattern 1,0,1; INSTR_D=NOP during the gap.
- CLR mid-stall: FULL with STALL_CNT=4, assert CLR -> all outputs at reset values next cycle, STALL_CNT=0.
- Saturation (CNT_W=3): hold VALID_D=1, READY_D=0 for 10 cycles -> STALL_CNT reaches 7 and stays at 7.
